// File: rtl/aes_data_out_fifo.sv
// -----------------------------------------------------------------------------
// aes_data_out_fifo
//
// Output-side buffer of the AES256 core, facing the host. Whole 128-bit
// blocks arrive from the core datapath over a valid/ready handshake. They are
// stored in BLK_DEPTH block slots and handed to the host as four 32-bit words,
// most significant word first. The host side is first-word-fall-through: the
// head word is always present on data_out, and rd_fifo pops it.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   resetn         synchronous, active-low reset
//   blk_in         block from the core; bits [127:96] are word 0
//   blk_valid      core presents a block on blk_in
//   blk_ready      a free block slot exists (depends only on registered state)
//   rd_fifo        host pops the current head word
//   data_out       current head word, 32'h0 while empty
//   empty_fifo     no words available
//   full_fifo      all BLK_DEPTH slots occupied
//   word_count     words available, 0..4*BLK_DEPTH
//   last_word      head word is word 3 of its block
//   underflow_err  sticky: rd_fifo was asserted while empty, cleared by reset
//
// Parameters:
//   BLK_DEPTH      number of 128-bit block slots, power of 2, minimum 2
//   CNT_W          width of word_count, 2**CNT_W > 4*BLK_DEPTH
// -----------------------------------------------------------------------------
module aes_data_out_fifo #(
  parameter int BLK_DEPTH = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [127:0]     blk_in,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             rd_fifo,
  output logic [31:0]      data_out,
  output logic             empty_fifo,
  output logic             full_fifo,
  output logic [CNT_W-1:0] word_count,
  output logic             last_word,
  output logic             underflow_err
);

  localparam int PTR_W  = (BLK_DEPTH > 1) ? $clog2(BLK_DEPTH) : 1;
  localparam int BCNT_W = $clog2(BLK_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Advance a block pointer, wrapping back to slot 0 after the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] res;
    if (ptr == PTR_W'(BLK_DEPTH - 1)) begin
      res = {PTR_W{1'b0}};
    end else begin
      res = ptr + PTR_W'(1);
    end
    return res;
  endfunction

  // Pick one 32-bit word out of a block; word 0 is the most significant.
  function automatic logic [31:0] sel_word(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [31:0] res;
    case (idx)
      2'd0:    res = blk[127:96];
      2'd1:    res = blk[95:64];
      2'd2:    res = blk[63:32];
      2'd3:    res = blk[31:0];
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [127:0]      storage_r [BLK_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [1:0]        word_idx_r;
  logic [BCNT_W-1:0] blk_count_r;
  logic              underflow_r;

  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [1:0]        word_idx_nxt_s;
  logic [BCNT_W-1:0] blk_count_nxt_s;
  logic              underflow_nxt_s;

  logic              empty_s;
  logic              full_s;
  logic              accept_s;
  logic              pop_s;
  logic              pop_last_s;
  logic [CNT_W-1:0]  wc_blk_s;
  logic [CNT_W-1:0]  wc_idx_s;

  // ---------------------------------------------------------------------------
  // Status and handshake decode, all from registered state
  // ---------------------------------------------------------------------------

  // Derive empty/full, the accept/pop qualifiers and the word count.
  always_comb begin
    empty_s    = (blk_count_r == {BCNT_W{1'b0}});
    full_s     = (blk_count_r == BCNT_W'(BLK_DEPTH));
    // blk_ready is a pure function of blk_count_r, so accept never sees a
    // same-cycle slot freed by a pop.
    accept_s   = blk_valid && !full_s;
    pop_s      = rd_fifo && !empty_s;
    pop_last_s = pop_s && (word_idx_r == 2'd3);
    // Words still held = all words of stored blocks minus those already
    // popped from the head block.
    wc_blk_s   = CNT_W'({blk_count_r, 2'b00});
    wc_idx_s   = CNT_W'(word_idx_r);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Compute pointer, word index, block count and sticky error updates.
  always_comb begin
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    word_idx_nxt_s  = word_idx_r;
    blk_count_nxt_s = blk_count_r;
    underflow_nxt_s = underflow_r;

    if (accept_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_last_s) begin
      word_idx_nxt_s = 2'd0;
      rd_ptr_nxt_s   = ptr_inc(rd_ptr_r);
    end else if (pop_s) begin
      word_idx_nxt_s = word_idx_r + 2'd1;
      rd_ptr_nxt_s   = rd_ptr_r;
    end else begin
      word_idx_nxt_s = word_idx_r;
      rd_ptr_nxt_s   = rd_ptr_r;
    end

    // A block arriving in the same cycle the head block retires leaves the
    // count unchanged.
    case ({accept_s, pop_last_s})
      2'b10:   blk_count_nxt_s = blk_count_r + BCNT_W'(1);
      2'b01:   blk_count_nxt_s = blk_count_r - BCNT_W'(1);
      default: blk_count_nxt_s = blk_count_r;
    endcase

    if (rd_fifo && empty_s) begin
      underflow_nxt_s = 1'b1;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      word_idx_r  <= 2'd0;
      blk_count_r <= {BCNT_W{1'b0}};
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      word_idx_r  <= word_idx_nxt_s;
      blk_count_r <= blk_count_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Block storage; not reset, written only on an accepted handshake outside
  // of reset so a handshake in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (resetn && accept_s) begin
      storage_r[wr_ptr_r] <= blk_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // Drive the host-facing status and FWFT head word.
  always_comb begin
    blk_ready     = !full_s;
    empty_fifo    = empty_s;
    full_fifo     = full_s;
    word_count    = wc_blk_s - wc_idx_s;
    last_word     = !empty_s && (word_idx_r == 2'd3);
    underflow_err = underflow_r;
    if (empty_s) begin
      data_out = 32'h0000_0000;
    end else begin
      data_out = sel_word(storage_r[rd_ptr_r], word_idx_r);
    end
  end

endmodule

// File: tb/tb_aes_data_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_aes_data_out_fifo
//
// Self-checking bench for aes_data_out_fifo. A reference model holds the
// buffered words as a plain queue of 32-bit words; every cycle the DUT status
// and head word are compared against values derived from that queue. Directed
// scenarios are followed by a randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_aes_data_out_fifo;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic          clk;
  logic          resetn;
  logic [127:0]  blk_in;
  logic          blk_valid;
  logic          blk_ready;
  logic          rd_fifo;
  logic [31:0]   data_out;
  logic          empty_fifo;
  logic          full_fifo;
  logic [CW-1:0] word_count;
  logic          last_word;
  logic          underflow_err;

  aes_data_out_fifo #(
    .BLK_DEPTH(DEPTH),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .blk_in       (blk_in),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .rd_fifo      (rd_fifo),
    .data_out     (data_out),
    .empty_fifo   (empty_fifo),
    .full_fifo    (full_fifo),
    .word_count   (word_count),
    .last_word    (last_word),
    .underflow_err(underflow_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words still to be delivered, oldest first.
  logic [31:0] m_q[$];
  logic        m_uflow = 1'b0;

  // Count one comparison and report it if it mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Blocks held = complete blocks plus the partially read head block.
  function automatic int m_blocks();
    return (m_q.size() + 3) / 4;
  endfunction

  // Compare every DUT output with the model.
  task automatic check_outputs();
    logic [31:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
    check_eq("data_out",   data_out,             exp_data);
    check_eq("word_count", 32'(word_count),      32'(m_q.size()));
    check_eq("empty",      32'(empty_fifo),      32'(m_q.size() == 0));
    check_eq("full",       32'(full_fifo),       32'(m_blocks() == DEPTH));
    check_eq("blk_ready",  32'(blk_ready),       32'(m_blocks() != DEPTH));
    check_eq("last_word",  32'(last_word),       32'(m_q.size() % 4 == 1));
    check_eq("underflow",  32'(underflow_err),   32'(m_uflow));
  endtask

  // One clock cycle: check outputs, drive inputs, clock, update the model.
  task automatic cycle(input logic v, input logic [127:0] b,
                       input logic r, input logic rn);
    bit full_pre;
    check_outputs();
    blk_valid = v;
    blk_in    = b;
    rd_fifo   = r;
    resetn    = rn;
    full_pre  = (m_blocks() == DEPTH);
    @(posedge clk);
    if (!rn) begin
      m_q.delete();
      m_uflow = 1'b0;
    end else begin
      if (r) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_uflow = 1'b1;
      end
      if (v && !full_pre) begin
        m_q.push_back(b[127:96]);
        m_q.push_back(b[95:64]);
        m_q.push_back(b[63:32]);
        m_q.push_back(b[31:0]);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] blk_a, blk_b, blk_c, blk_k;

  initial begin
    resetn    = 1'b0;
    blk_valid = 1'b0;
    blk_in    = 128'h0;
    rd_fifo   = 1'b0;
    @(negedge clk);

    // Reset then idle.
    cycle(1'b0, 128'h0, 1'b0, 1'b0);
    check_eq("rst_empty",  32'(empty_fifo), 32'd1);
    check_eq("rst_ready",  32'(blk_ready),  32'd1);
    check_eq("rst_count",  32'(word_count), 32'd0);
    check_eq("rst_data",   data_out,        32'h0);
    check_eq("rst_full",   32'(full_fifo),  32'd0);
    check_eq("rst_last",   32'(last_word),  32'd0);

    // Underflow is sticky until reset.
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("uflow_set", 32'(underflow_err), 32'd1);
    cycle(1'b0, 128'h0, 1'b0, 1'b1);
    cycle(1'b0, 128'h0, 1'b0, 1'b1);
    check_eq("uflow_hold", 32'(underflow_err), 32'd1);
    cycle(1'b0, 128'h0, 1'b0, 1'b0);
    check_eq("uflow_clr", 32'(underflow_err), 32'd0);

    // Single block, sequential pops.
    cycle(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 1'b1);
    check_eq("sb_w0",    data_out,        32'h00112233);
    check_eq("sb_cnt",   32'(word_count), 32'd4);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("sb_w1",    data_out,        32'h44556677);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("sb_w2",    data_out,        32'h8899AABB);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("sb_w3",    data_out,        32'hCCDDEEFF);
    check_eq("sb_last",  32'(last_word),  32'd1);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("sb_empty", 32'(empty_fifo), 32'd1);

    // Fill to full, block C waits for a free slot.
    blk_a = rand_blk();
    blk_b = rand_blk();
    blk_c = rand_blk();
    cycle(1'b1, blk_a, 1'b0, 1'b1);
    cycle(1'b1, blk_b, 1'b0, 1'b1);
    check_eq("fill_full",  32'(full_fifo),  32'd1);
    check_eq("fill_ready", 32'(blk_ready),  32'd0);
    check_eq("fill_cnt",   32'(word_count), 32'd8);
    for (int i = 0; i < 3; i++) cycle(1'b1, blk_c, 1'b1, 1'b1);
    check_eq("fill_c_wait", 32'(word_count), 32'd5);
    cycle(1'b1, blk_c, 1'b1, 1'b1);
    check_eq("fill_ready_back", 32'(blk_ready),  32'd1);
    check_eq("fill_c_not_yet",  32'(word_count), 32'd4);
    check_eq("fill_b_head",     data_out,        blk_b[127:96]);
    cycle(1'b1, blk_c, 1'b0, 1'b1);
    check_eq("fill_c_in", 32'(word_count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("fill_drained", 32'(empty_fifo), 32'd1);

    // Simultaneous accept and last-word pop, streamed across pointer wrap.
    cycle(1'b0, 128'h0, 1'b0, 1'b0);
    cycle(1'b1, rand_blk(), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) cycle(1'b0, 128'h0, 1'b1, 1'b1);
      blk_k = rand_blk();
      cycle(1'b1, blk_k, 1'b1, 1'b1);
      check_eq("strm_cnt",  32'(word_count), 32'd4);
      check_eq("strm_full", 32'(full_fifo),  32'd0);
      check_eq("strm_w0",   data_out,        blk_k[127:96]);
    end
    for (int j = 0; j < 4; j++) cycle(1'b0, 128'h0, 1'b1, 1'b1);

    // Reset mid-stream with a handshake and a pop in the reset cycle.
    cycle(1'b1, rand_blk(), 1'b0, 1'b1);
    cycle(1'b1, rand_blk(), 1'b0, 1'b1);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    cycle(1'b0, 128'h0, 1'b1, 1'b1);
    check_eq("mid_cnt6", 32'(word_count), 32'd6);
    cycle(1'b1, rand_blk(), 1'b1, 1'b0);
    check_eq("mid_cnt0",  32'(word_count), 32'd0);
    check_eq("mid_empty", 32'(empty_fifo), 32'd1);
    check_eq("mid_data",  data_out,        32'h0);
    cycle(1'b0, 128'h0, 1'b0, 1'b1);
    check_eq("mid_nostore", 32'(empty_fifo), 32'd1);

    // Randomized traffic with occasional resets; every cycle is checked.
    for (int i = 0; i < 3000; i++) begin
      logic v, r, rn;
      v  = ($urandom_range(0, 99) < 45);
      r  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 85));
      rn = ($urandom_range(0, 199) != 0);
      cycle(v, rand_blk(), r, rn);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
